vga_scan_timing: RTL and testbench

//  Downstream display stage: turns the processor's pixel stream into a VGA raster. Generates the
//  640x480@60 timing (HS/VS) from the system clock using a pixel-tick divider.

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_scan_timing_if.sv | 26 ++
 rtl/vga_pixel_tick.sv | 22 ++
 rtl/vga_scan_timing.sv | 106 ++++++++++
 tb/tb_vga_scan_timing.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 640x480@60 raster constants, RGB444 pixel type,
// and the per-pixel tag that travels down the timing block's delay line.
package vga_pkg;

    localparam int RGB_W = 12;
    typedef logic [RGB_W-1:0] rgb444_t;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One scan axis: visible span, front porch, sync width, back porch.
    typedef struct packed {
        logic [9:0] active;
        logic [9:0] fp;
        logic [9:0] sync;
        logic [9:0] bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h: '{H_ACTIVE, H_FP, H_SYNC, H_BP},
        v: '{V_ACTIVE, V_FP, V_SYNC, V_BP}
    };

    // Raw decode of one pixel position; stb marks the clk it was issued.
    typedef struct packed {
        logic stb;
        logic vis;
        logic hs;
        logic vs;
    } scan_tag_t;

endpackage

// File: rtl/vga_scan_timing_if.sv
// Fetch bus to the upstream pixel source plus the video outputs to the DAC.
interface vga_scan_timing_if;
    import vga_pkg::*;

    rgb444_t    pix_in;
    logic       fetch_en;
    logic [9:0] fetch_x;
    logic [9:0] fetch_y;
    logic       frame_start;
    rgb444_t    COLOR_OUT;
    logic       HS;
    logic       VS;
    logic       active;

    modport master (
        input  pix_in,
        output fetch_en, fetch_x, fetch_y, frame_start,
        output COLOR_OUT, HS, VS, active
    );

    modport slave (
        output pix_in,
        input  fetch_en, fetch_x, fetch_y, frame_start,
        input  COLOR_OUT, HS, VS, active
    );
endinterface

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: tick is high for one clk out of every CLK_DIV.
module vga_pixel_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int         W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    // Free-running modulo-CLK_DIV counter.
    always_ff @(posedge clk) begin
        if (rst)                 div_cnt <= '0;
        else if (div_cnt == LAST) div_cnt <= '0;
        else                     div_cnt <= div_cnt + W'(1);
    end

    assign tick = (div_cnt == LAST);
endmodule

// File: rtl/vga_scan_timing.sv
// VGA raster generator: walks the h/v counters at the pixel rate, issues a fetch
// for each visible pixel, and re-aligns sync/blanking with the returned pixel.
module vga_scan_timing
    import vga_pkg::*;
#(
    parameter vga_timing_t TIM       = VGA_640X480,
    parameter int          CLK_DIV   = 4,
    parameter int          SYNC_POL  = 0,
    parameter int          FETCH_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    vga_scan_timing_if.master bus
);
    localparam logic [9:0] H_ACT  = TIM.h.active;
    localparam logic [9:0] H_SS   = TIM.h.active + TIM.h.fp;
    localparam logic [9:0] H_SE   = H_SS + TIM.h.sync;
    localparam logic [9:0] H_LAST = H_SE + TIM.h.bp - 10'd1;
    localparam logic [9:0] V_ACT  = TIM.v.active;
    localparam logic [9:0] V_SS   = TIM.v.active + TIM.v.fp;
    localparam logic [9:0] V_SE   = V_SS + TIM.v.sync;
    localparam logic [9:0] V_LAST = V_SE + TIM.v.bp - 10'd1;
    // Level of HS/VS when the pulse is not active.
    localparam logic       SYNC_IDLE = (SYNC_POL == 0);

    logic       tick, tick_q;
    logic [9:0] h_cnt, v_cnt;
    scan_tag_t  raw;
    scan_tag_t  pipe [FETCH_LAT];

    vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Decode of the current raster position.
    always_comb begin
        raw     = '0;
        raw.stb = tick_q;
        raw.vis = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        raw.hs  = (h_cnt >= H_SS) && (h_cnt < H_SE);
        raw.vs  = (v_cnt >= V_SS) && (v_cnt < V_SE);
    end

    // Raster counters; tick is registered so decode has a full clk to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            tick_q <= tick;
            if (tick_q) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    // Stage 0: fetch request and frame marker; coordinates hold between fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fetch_en    <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.fetch_x     <= '0;
            bus.fetch_y     <= '0;
        end else begin
            bus.fetch_en    <= tick_q && raw.vis;
            bus.frame_start <= tick_q && (h_cnt == '0) && (v_cnt == '0);
            if (tick_q && raw.vis) begin
                bus.fetch_x <= h_cnt;
                bus.fetch_y <= v_cnt;
            end
        end
    end

    // Delay line carrying the pixel tag until its data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FETCH_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= raw;
            for (int i = 1; i < FETCH_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Stage 1: all video outputs move together on the capture clk only.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.COLOR_OUT <= '0;
            bus.active    <= 1'b0;
            bus.HS        <= SYNC_IDLE;
            bus.VS        <= SYNC_IDLE;
        end else if (pipe[FETCH_LAT-1].stb) begin
            bus.COLOR_OUT <= pipe[FETCH_LAT-1].vis ? bus.pix_in : '0;
            bus.active    <= pipe[FETCH_LAT-1].vis;
            bus.HS        <= pipe[FETCH_LAT-1].hs ^ SYNC_IDLE;
            bus.VS        <= pipe[FETCH_LAT-1].vs ^ SYNC_IDLE;
        end
    end
endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: three instances (full 640x480 raster, and two tiny
// rasters with other divider/latency/polarity settings) checked every clk against
// an arithmetic model indexed by clks since reset, plus literal spot checks.
module tb_vga_scan_timing;
    import vga_pkg::*;

    typedef struct {
        int cd, lat, pol, ha, hf, hs, hb, va, vf, vs, vb;
    } cfg_t;

    typedef struct {
        int fetch_en, fetch_x, fetch_y, frame_start, color, hs, vs, active;
    } exp_t;

    localparam vga_timing_t TIM_B = '{h: '{10'd8, 10'd2, 10'd3, 10'd3},
                                      v: '{10'd4, 10'd1, 10'd2, 10'd1}};
    localparam vga_timing_t TIM_C = '{h: '{10'd6, 10'd1, 10'd2, 10'd1},
                                      v: '{10'd3, 10'd1, 10'd1, 10'd1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k = 0;
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;
    cfg_t cfgs [3];
    int   fetch_cnt_a = 0;
    int   fs_cnt_b = 0;
    int   cd_a = -1, cd_b = -1, cd_c = -1;
    logic [11:0] sv_a = '0, sv_b = '0, sv_c = '0;

    vga_scan_timing_if ifa ();
    vga_scan_timing_if ifb ();
    vga_scan_timing_if ifc ();

    vga_scan_timing #(.TIM(VGA_640X480), .CLK_DIV(4), .SYNC_POL(0), .FETCH_LAT(1))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    vga_scan_timing #(.TIM(TIM_B), .CLK_DIV(4), .SYNC_POL(0), .FETCH_LAT(2))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    vga_scan_timing #(.TIM(TIM_C), .CLK_DIV(2), .SYNC_POL(1), .FETCH_LAT(1))
        u_c (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    // Clks since reset released (0 while held in reset).
    always @(posedge clk) k <= rst ? 0 : k + 1;

    function automatic int pix_of(int h, int v);
        return ((h & 15) << 8) | ((v & 15) << 4) | 10;
    endfunction

    // Expected outputs after the k-th post-reset clk edge. Pixel m is issued at
    // clk cd+1+m*cd and displayed lat clks later; raster position is m mod frame.
    function automatic exp_t model(cfg_t c, int kk);
        exp_t e;
        int ht, vt, m, p, h, v, idle;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        idle = (c.pol == 0) ? 1 : 0;
        e = '{0, 0, 0, 0, 0, idle, idle, 0};
        if (kk >= c.cd + 1) begin
            m = (kk - c.cd - 1) / c.cd;
            p = m % (ht * vt);
            h = p % ht;
            v = p / ht;
            if ((kk - c.cd - 1) % c.cd == 0) begin
                e.fetch_en    = (h < c.ha && v < c.va) ? 1 : 0;
                e.frame_start = (p == 0) ? 1 : 0;
            end
            if (h < c.ha && v < c.va) begin e.fetch_x = h;        e.fetch_y = v; end
            else if (v < c.va)        begin e.fetch_x = c.ha - 1; e.fetch_y = v; end
            else                      begin e.fetch_x = c.ha - 1; e.fetch_y = c.va - 1; end
        end
        if (kk >= c.cd + 1 + c.lat) begin
            m = (kk - c.cd - 1 - c.lat) / c.cd;
            p = m % (ht * vt);
            h = p % ht;
            v = p / ht;
            e.active = (h < c.ha && v < c.va) ? 1 : 0;
            e.color  = e.active ? pix_of(h, v) : 0;
            e.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? 1 - idle : idle;
            e.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? 1 - idle : idle;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s k=%0d got %0h want %0h", name, k, act, exp);
        end
    endtask

    task automatic cmp(input string p, input int id, input logic fe,
                       input logic [9:0] fx, input logic [9:0] fy, input logic fs,
                       input logic [11:0] col, input logic hs, input logic vs,
                       input logic act);
        exp_t e;
        e = model(cfgs[id], k);
        chk({p, ".fetch_en"},    int'(fe),  e.fetch_en);
        chk({p, ".fetch_x"},     int'(fx),  e.fetch_x);
        chk({p, ".fetch_y"},     int'(fy),  e.fetch_y);
        chk({p, ".frame_start"}, int'(fs),  e.frame_start);
        chk({p, ".COLOR_OUT"},   int'(col), e.color);
        chk({p, ".HS"},          int'(hs),  e.hs);
        chk({p, ".VS"},          int'(vs),  e.vs);
        chk({p, ".active"},      int'(act), e.active);
    endtask

    // Upstream source: answers a fetch so the data is on pix_in at the capture
    // edge lat clks later; every other clk carries random junk.
    task automatic upstream(input int lat, input logic fe, input logic [9:0] fx,
                            input logic [9:0] fy, inout int cd, inout logic [11:0] sv,
                            output logic [11:0] pix);
        if (fe) begin
            cd = lat - 1;
            sv = {fx[3:0], fy[3:0], 4'hA};
        end
        if (cd == 0) begin
            pix = sv;
            cd  = -1;
        end else begin
            if (cd > 0) cd--;
            pix = 12'($urandom);
        end
    endtask

    always @(posedge clk) begin
        #1;
        upstream(1, ifa.fetch_en, ifa.fetch_x, ifa.fetch_y, cd_a, sv_a, ifa.pix_in);
        upstream(2, ifb.fetch_en, ifb.fetch_x, ifb.fetch_y, cd_b, sv_b, ifb.pix_in);
        upstream(1, ifc.fetch_en, ifc.fetch_x, ifc.fetch_y, cd_c, sv_c, ifc.pix_in);
    end

    // Per-clk compare against the model, plus literal pins.
    always @(negedge clk) begin
        if (started) begin
            cmp("a", 0, ifa.fetch_en, ifa.fetch_x, ifa.fetch_y, ifa.frame_start,
                ifa.COLOR_OUT, ifa.HS, ifa.VS, ifa.active);
            cmp("b", 1, ifb.fetch_en, ifb.fetch_x, ifb.fetch_y, ifb.frame_start,
                ifb.COLOR_OUT, ifb.HS, ifb.VS, ifb.active);
            cmp("c", 2, ifc.fetch_en, ifc.fetch_x, ifc.fetch_y, ifc.frame_start,
                ifc.COLOR_OUT, ifc.HS, ifc.VS, ifc.active);

            if (k == 0) begin fetch_cnt_a = 0; fs_cnt_b = 0; end
            if (k >= 1 && ifa.fetch_en)    fetch_cnt_a++;
            if (k >= 1 && ifb.frame_start) fs_cnt_b++;

            if (k == 4)    chk("pin.a_no_early_fetch", int'(ifa.fetch_en), 0);
            if (k == 5) begin
                chk("pin.a_first_fetch", int'(ifa.fetch_en), 1);
                chk("pin.a_first_fs",    int'(ifa.frame_start), 1);
                chk("pin.b_first_fs",    int'(ifb.frame_start), 1);
            end
            if (k == 6)    chk("pin.a_first_color", int'(ifa.COLOR_OUT), 'h00A);
            if (k == 2565) chk("pin.a_active_639", int'(ifa.active), 1);
            if (k == 2566) chk("pin.a_active_640", int'(ifa.active), 0);
            if (k == 2629) chk("pin.a_hs_before", int'(ifa.HS), 1);
            if (k == 2630) chk("pin.a_hs_start", int'(ifa.HS), 0);
            if (k == 3013) chk("pin.a_hs_last", int'(ifa.HS), 0);
            if (k == 3014) chk("pin.a_hs_end", int'(ifa.HS), 1);
            if (k == 3204) chk("pin.a_fetches_line0", fetch_cnt_a, 640);
            if (k == 3205) begin
                chk("pin.a_line1_fetch", int'(ifa.fetch_en), 1);
                chk("pin.a_line1_y", int'(ifa.fetch_y), 1);
            end
            if (k == 227)  chk("pin.b_last_vis_color", int'(ifb.COLOR_OUT), 'h73A);
            if (k == 231) begin
                chk("pin.b_blank_color", int'(ifb.COLOR_OUT), 0);
                chk("pin.b_blank_active", int'(ifb.active), 0);
            end
            if (k == 326)  chk("pin.b_vs_before", int'(ifb.VS), 1);
            if (k == 327)  chk("pin.b_vs_start", int'(ifb.VS), 0);
            if (k == 517)  chk("pin.b_wrap_fs", int'(ifb.frame_start), 1);
            if (k == 1100) chk("pin.b_fs_count", fs_cnt_b, 3);
            if (k == 3)    chk("pin.c_first_fs", int'(ifc.frame_start), 1);
            if (k == 123)  chk("pin.c_wrap_fs", int'(ifc.frame_start), 1);
            if (k == 17)   chk("pin.c_hs_idle", int'(ifc.HS), 0);
            if (k == 18)   chk("pin.c_hs_active_high", int'(ifc.HS), 1);
        end
    end

    initial begin
        cfgs[0] = '{4, 1, 0, 640, 16, 96, 48, 480, 10, 2, 33};
        cfgs[1] = '{4, 2, 0, 8, 2, 3, 3, 4, 1, 2, 1};
        cfgs[2] = '{2, 1, 1, 6, 1, 2, 1, 3, 1, 1, 1};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        started = 1'b1;
        rst = 1'b0;
        repeat (7000) @(negedge clk);
        // Long reset mid-line.
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (1205) @(negedge clk);
        // One-clk reset around pixel (300,0) of the full raster.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (1500) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
